pwm_multi_ch: RTL

Parametrised multi-channel PWM generator that succeeds the single-channel UART-fed PWM block. A single shared prescaler drives one period counter. Each of CH_NUM channels compares that counter against its own duty value. Duty updates are double-buffered and applied only at the period boundary, so every period is glitch-free. It sits between the UART receive path (duty source) and the output pins, driven from the board clock.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_prescaler.sv | 37 +++
 rtl/pwm_multi_ch.sv | 113 +++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator and its prescaler.
package pwm_pkg;

   localparam int PWM_WIDTH   = 8;
   localparam int PWM_DIV     = 4096;
   localparam int PWM_CH      = 2;
   localparam int PWM_BUS_MAX = 1024;

   function automatic int clog2(input int unsigned value);
      int result;
      result = 0;
      while ((64'd1 << result) < 64'(value)) result = result + 1;
      return result;
   endfunction

   // Callers zero-extend their packed duty bus to PWM_BUS_MAX bits before slicing.
   function automatic logic [31:0] duty_slice(input logic [PWM_BUS_MAX-1:0] bus,
                                              input int idx, input int width);
      logic [PWM_BUS_MAX-1:0] shifted;
      shifted = bus >> (idx * width);
      return shifted[31:0] & ((32'd1 << width) - 32'd1);
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running clock-enable generator: TICK is high for one CLK every DIV cycles while EN is high.
module pwm_prescaler
   import pwm_pkg::*;
#(
   parameter int DIV = PWM_DIV
) (
   input  logic CLK,
   input  logic RST,
   input  logic EN,
   output logic TICK
);

   localparam int            PW   = (clog2(DIV) < 1) ? 1 : clog2(DIV);
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] count_q;
   logic [PW-1:0] count_d;

   always_comb begin
      TICK    = EN && (count_q == LAST);
      count_d = count_q;
      if (!EN || TICK) begin
         count_d = '0;
      end else begin
         count_d = count_q + PW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: one shared period counter, per-channel duty compare with
// double-buffered duty values that only take effect at the period boundary.
module pwm_multi_ch
   import pwm_pkg::*;
#(
   parameter int                CH_NUM     = PWM_CH,
   parameter int                WIDTH      = PWM_WIDTH,
   parameter int                DIV        = PWM_DIV,
   parameter logic [CH_NUM-1:0] ACTIVE_LOW = {CH_NUM{1'b0}}
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    EN,
   input  logic [CH_NUM*WIDTH-1:0] DUTY_IN,
   input  logic                    DUTY_WR,
   output logic                    PEND,
   output logic                    PERIOD_START,
   output logic [CH_NUM-1:0]       PWM_OUT
);

   logic             tick;
   logic             boundary;
   logic [WIDTH-1:0] cntr_q;
   logic [WIDTH-1:0] cntr_d;
   logic             pend_q;
   logic             pend_d;
   logic             period_start_q;
   logic             period_start_d;

   pwm_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .CLK  (CLK),
      .RST  (RST),
      .EN   (EN),
      .TICK (tick)
   );

   // A write in the boundary cycle wins over the boundary clearing PEND.
   always_comb begin
      boundary = tick && (cntr_q == '1);
      cntr_d   = cntr_q;
      if (!EN) begin
         cntr_d = '0;
      end else if (tick) begin
         cntr_d = cntr_q + WIDTH'(1);
      end
      pend_d = pend_q;
      if (DUTY_WR) begin
         pend_d = 1'b1;
      end else if (boundary) begin
         pend_d = 1'b0;
      end
      period_start_d = boundary;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cntr_q         <= '0;
         pend_q         <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         cntr_q         <= cntr_d;
         pend_q         <= pend_d;
         period_start_q <= period_start_d;
      end
   end

   assign PEND         = pend_q;
   assign PERIOD_START = period_start_q;

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      logic [WIDTH-1:0] active_q;
      logic [WIDTH-1:0] active_d;
      logic [WIDTH-1:0] pending_q;
      logic [WIDTH-1:0] pending_d;
      logic             pwm_q;
      logic             pwm_d;

      // Compare against post-update counter and duty so a new duty lands on the first tick.
      always_comb begin
         pending_d = pending_q;
         if (DUTY_WR) begin
            pending_d = WIDTH'(duty_slice(PWM_BUS_MAX'(DUTY_IN), i, WIDTH));
         end
         active_d = active_q;
         if (boundary && pend_q) begin
            active_d = pending_q;
         end
         pwm_d = pwm_q;
         if (!EN) begin
            pwm_d = ACTIVE_LOW[i];
         end else if (tick) begin
            pwm_d = (cntr_d < active_d) ^ ACTIVE_LOW[i];
         end
      end

      always_ff @(posedge CLK) begin
         if (RST) begin
            active_q  <= '0;
            pending_q <= '0;
            pwm_q     <= ACTIVE_LOW[i];
         end else begin
            active_q  <= active_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
         end
      end

      assign PWM_OUT[i] = pwm_q;
   end

endmodule
